// File: rtl/pe.sv
// rtl/pe.sv - unsigned multiply processing element with registered full-precision product
module pe #(
  parameter int input_width  = 8,
  parameter int output_width = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [input_width-1:0]  ifm_input,
  input  logic [input_width-1:0]  wgt_input,
  output logic [output_width-1:0] product_output
);

  generate
    if (output_width != 2 * input_width) begin : g_width_check
      $error("pe: output_width must equal 2*input_width");
    end
  endgenerate

  logic [output_width-1:0] rows [input_width];
  logic [output_width-1:0] product;

  // One AND-gated row per weight bit, shifted to that bit's weight.
  always_comb begin
    for (int i = 0; i < input_width; i++) begin
      rows[i] = (output_width'(ifm_input) & {output_width{wgt_input[i]}}) << i;
    end
  end

  always_comb begin
    product = '0;
    for (int i = 0; i < input_width; i++) begin
      product = product + rows[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_output <= '0;
    end else begin
      product_output <= product;
    end
  end

endmodule

// File: tb/tb_pe.sv
// tb/tb_pe.sv - scoreboard testbench for pe
module tb_pe;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ifm;
  logic [7:0]  wgt;
  logic [15:0] product;

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_q [$];

  pe #(.input_width(8), .output_width(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifm_input      (ifm),
    .wgt_input      (wgt),
    .product_output (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    ifm = a;
    wgt = b;
    exp_q.push_back(16'(a) * 16'(b));
  endtask

  // Monitor: the DUT presents a new product after every rising edge out of reset.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("product", product, e);
      end
    end
  end

  initial begin
    static logic [7:0] sa [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    static logic [7:0] sb [8] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    int budget;

    rst_n = 1'b0;
    ifm   = 8'hFF;
    wgt   = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_hold", product, 16'h0000);
    end

    // Release and issue the first pair in the same low phase.
    @(negedge clk);
    rst_n = 1'b1;
    ifm   = 8'd1;
    wgt   = 8'd2;
    exp_q.push_back(16'd2);
    #1;
    chk("single_before_edge", product, 16'h0000);

    for (int i = 0; i < 8; i++) issue(sa[i], sb[i]);

    issue(8'd255, 8'd255);
    issue(8'd255, 8'd1);
    issue(8'd0,   8'd200);
    issue(8'd128, 8'd2);

    // Stream up to 42, then reset asynchronously between edges.
    for (int i = 0; i < 6; i++) issue(sa[i], sb[i]);
    @(posedge clk);
    #3;
    chk("pre_reset_value", product, 16'd42);
    rst_n = 1'b0;
    ifm   = 8'd9;
    wgt   = 8'd9;
    #1;
    chk("async_reset", product, 16'h0000);
    @(posedge clk);
    #1;
    chk("reset_discard", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    ifm   = 8'd8;
    wgt   = 8'd9;
    exp_q.push_back(16'd72);

    for (int i = 0; i < 1000; i++) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d outstanding expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
